// File: rtl/int_event_latch.sv
// Interrupt event latch: synchronizes 16 raw event lines, latches edge/level detects as pending
// bits for the interrupt controller and records events lost while a bit was already pending.
module int_event_latch (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Addr,
    output logic [15:0] DataRd,
    input  logic [15:0] DataWr,
    input  logic        En,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Events,
    input  logic [15:0] IntReset,
    output logic [15:0] IntStatus
);

    localparam logic [3:0] AddrModeLo  = 4'd0;
    localparam logic [3:0] AddrModeHi  = 4'd1;
    localparam logic [3:0] AddrEnable  = 4'd2;
    localparam logic [3:0] AddrPending = 4'd3;
    localparam logic [3:0] AddrOverrun = 4'd4;

    localparam logic [1:0] ModeRise  = 2'b00;
    localparam logic [1:0] ModeFall  = 2'b01;
    localparam logic [1:0] ModeBoth  = 2'b10;
    localparam logic [1:0] ModeLevel = 2'b11;

    logic [15:0] modeLo;
    logic [15:0] modeHi;
    logic [15:0] enable;
    logic [15:0] pending;
    logic [15:0] overrun;

    logic [15:0] sync1;
    logic [15:0] sync2;
    logic [15:0] prev;

    logic [3:0]  addrSync;
    logic        enSync;
    logic        wrSync;
    logic        wrSyncPrev;
    logic        writeCommit;

    logic [31:0] modeAll;
    logic [15:0] rawDetect;
    logic [15:0] detect;
    logic [15:0] levelMode;
    logic [15:0] overrunSet;
    logic [15:0] overrunClr;

    // Read strobe has no side effects; it is accepted but not used.
    logic unusedRd;
    assign unusedRd = Rd;

    assign modeAll     = {modeHi, modeLo};
    assign writeCommit = wrSync & ~wrSyncPrev & enSync;

    always_comb begin
        rawDetect = '0;
        levelMode = '0;
        for (int ch = 0; ch < 16; ch++) begin
            unique case (modeAll[2*ch +: 2])
                ModeRise:  rawDetect[ch] = sync2[ch] & ~prev[ch];
                ModeFall:  rawDetect[ch] = ~sync2[ch] & prev[ch];
                ModeBoth:  rawDetect[ch] = sync2[ch] ^ prev[ch];
                ModeLevel: begin
                    rawDetect[ch] = sync2[ch];
                    levelMode[ch] = 1'b1;
                end
            endcase
        end
    end

    assign detect = rawDetect & enable;

    // A clear pulse coinciding with a detect consumes the old event, so it is not an overrun.
    assign overrunSet = detect & pending & ~IntReset & ~levelMode;
    assign overrunClr = (writeCommit && (addrSync == AddrOverrun)) ? DataWr : 16'h0000;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            modeLo     <= '0;
            modeHi     <= '0;
            enable     <= '0;
            pending    <= '0;
            overrun    <= '0;
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            addrSync   <= '0;
            enSync     <= 1'b0;
            wrSync     <= 1'b0;
            wrSyncPrev <= 1'b0;
        end else begin
            sync1      <= Events;
            sync2      <= sync1;
            prev       <= sync2;
            addrSync   <= Addr;
            enSync     <= En;
            wrSync     <= Wr;
            wrSyncPrev <= wrSync;
            pending    <= detect | (pending & ~IntReset);
            overrun    <= (overrun & ~overrunClr) | overrunSet;
            if (writeCommit) begin
                case (addrSync)
                    AddrModeLo: modeLo <= DataWr;
                    AddrModeHi: modeHi <= DataWr;
                    AddrEnable: enable <= DataWr;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        DataRd = 16'h0000;
        case (Addr)
            AddrModeLo:  DataRd = modeLo;
            AddrModeHi:  DataRd = modeHi;
            AddrEnable:  DataRd = enable;
            AddrPending: DataRd = pending;
            AddrOverrun: DataRd = overrun;
            default:     DataRd = 16'h0000;
        endcase
    end

    assign IntStatus = pending;

endmodule

// File: tb/tb_int_event_latch.sv
// Bench for int_event_latch: directed scenarios plus randomized traffic against a
// sample-history reference model of the event latch.
module tb_int_event_latch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  Addr = '0;
    logic [15:0] DataRd;
    logic [15:0] DataWr = '0;
    logic        En = 1'b0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] Events = '0;
    logic [15:0] IntReset = '0;
    logic [15:0] IntStatus;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 Clk = ~Clk;

    int_event_latch dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Addr      (Addr),
        .DataRd    (DataRd),
        .DataWr    (DataWr),
        .En        (En),
        .Rd        (Rd),
        .Wr        (Wr),
        .Events    (Events),
        .IntReset  (IntReset),
        .IntStatus (IntStatus)
    );

    // Reference model: keeps the last few input samples seen at clock edges and applies the
    // documented latencies (event: 2 edges after sampling, write: 1 edge after Wr rise seen).
    logic [15:0] mModeLo = '0, mModeHi = '0, mEnable = '0, mPending = '0, mOverrun = '0;
    logic [15:0] evSeen [0:2];
    logic        wrSeen [0:1];
    logic        enSeen;
    logic [3:0]  addrSeen;
    logic [15:0] mCur, mOld, mDet, mLvl, mW1c, mNewPend, mNewOvr;
    logic [31:0] mModes;
    int unsigned mCode;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mModeLo = '0; mModeHi = '0; mEnable = '0; mPending = '0; mOverrun = '0;
            for (int i = 0; i < 3; i++) evSeen[i] = '0;
            wrSeen[0] = 1'b0; wrSeen[1] = 1'b0; enSeen = 1'b0; addrSeen = '0;
        end else begin
            mCur = evSeen[1];
            mOld = evSeen[2];
            mModes = {mModeHi, mModeLo};
            mDet = '0;
            mLvl = '0;
            for (int c = 0; c < 16; c++) begin
                mCode = (mModes >> (2 * c)) & 32'd3;
                if (mCode == 0) mDet[c] = mCur[c] && !mOld[c];
                else if (mCode == 1) mDet[c] = !mCur[c] && mOld[c];
                else if (mCode == 2) mDet[c] = mCur[c] != mOld[c];
                else begin
                    mDet[c] = mCur[c];
                    mLvl[c] = 1'b1;
                end
            end
            mDet = mDet & mEnable;
            mNewOvr = mDet & mPending & ~IntReset & ~mLvl;
            mNewPend = mDet | (mPending & ~IntReset);
            mW1c = '0;
            if (wrSeen[0] && !wrSeen[1] && enSeen) begin
                if (addrSeen == 0) mModeLo = DataWr;
                else if (addrSeen == 1) mModeHi = DataWr;
                else if (addrSeen == 2) mEnable = DataWr;
                else if (addrSeen == 4) mW1c = DataWr;
            end
            mOverrun = (mOverrun & ~mW1c) | mNewOvr;
            mPending = mNewPend;
            evSeen[2] = evSeen[1]; evSeen[1] = evSeen[0]; evSeen[0] = Events;
            wrSeen[1] = wrSeen[0]; wrSeen[0] = Wr; enSeen = En; addrSeen = Addr;
        end
    end

    function automatic logic [15:0] expRead(input logic [3:0] a);
        case (a)
            4'd0: return mModeLo;
            4'd1: return mModeHi;
            4'd2: return mEnable;
            4'd3: return mPending;
            4'd4: return mOverrun;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic doReset();
        @(negedge Clk);
        Events = '0; IntReset = '0; Wr = 1'b0; En = 1'b0;
        Reset = 1'b1;
        waitCycles(2);
        Reset = 1'b0;
        waitCycles(1);
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [15:0] d, input int hold);
        @(negedge Clk);
        Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
        repeat (hold) @(negedge Clk);
        Wr = 1'b0;
        @(negedge Clk);
        En = 1'b0;
        waitCycles(2);
    endtask

    task automatic test_reset();
        doReset();
        busWrite(4'd0, 16'hFFFF, 1);
        busWrite(4'd1, 16'hFFFF, 1);
        busWrite(4'd2, 16'hFFFF, 1);
        Events = 16'hFFFF;
        waitCycles(4);
        nCompared++;
        if (IntStatus !== 16'hFFFF) begin
            nMismatched++;
            $display("FAIL reset_preload: IntStatus=%h expected %h", IntStatus, 16'hFFFF);
        end
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        nCompared++;
        if (IntStatus !== 16'h0000) begin
            nMismatched++;
            $display("FAIL reset_async: IntStatus=%h expected 0000", IntStatus);
        end
        Events = '0;
        for (int a = 0; a < 16; a++) begin
            Addr = 4'(a);
            #1;
            nCompared++;
            if (DataRd !== 16'h0000) begin
                nMismatched++;
                $display("FAIL reset_read[%0d]: DataRd=%h expected 0000", a, DataRd);
            end
        end
        @(negedge Clk) Reset = 1'b0;
        waitCycles(4);
        nCompared++;
        if (IntStatus !== 16'h0000) begin
            nMismatched++;
            $display("FAIL reset_release: IntStatus=%h expected 0000", IntStatus);
        end
        // Write aborted by a reset landing between Wr sample and commit.
        @(negedge Clk);
        Addr = 4'd2; DataWr = 16'hFFFF; En = 1'b1; Wr = 1'b1;
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1 Wr = 1'b0; En = 1'b0;
        @(negedge Clk) Reset = 1'b0;
        waitCycles(3);
        nCompared++;
        if (DataRd !== 16'h0000 || DataRd !== expRead(4'd2)) begin
            nMismatched++;
            $display("FAIL reset_abort_write: Enable=%h expected 0000", DataRd);
        end
    endtask

    task automatic test_rising();
        doReset();
        busWrite(4'd2, 16'h0001, 1);
        busWrite(4'd0, 16'h0000, 1);
        @(negedge Clk) Events = 16'h0001;
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h0000) begin
            nMismatched++;
            $display("FAIL rise_edge_k: IntStatus=%h expected 0000", IntStatus);
        end
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h0000) begin
            nMismatched++;
            $display("FAIL rise_edge_k1: IntStatus=%h expected 0000", IntStatus);
        end
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h0001) begin
            nMismatched++;
            $display("FAIL rise_edge_k2: IntStatus=%h expected 0001", IntStatus);
        end
        @(negedge Clk) Events = 16'h0000;
        waitCycles(4);
        nCompared++;
        if (IntStatus !== 16'h0001 || IntStatus !== mPending) begin
            nMismatched++;
            $display("FAIL rise_hold: IntStatus=%h expected 0001", IntStatus);
        end
        IntReset = 16'h0001;
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h0000) begin
            nMismatched++;
            $display("FAIL rise_clear: IntStatus=%h expected 0000", IntStatus);
        end
        @(negedge Clk) IntReset = 16'h0000;
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0000) begin
            nMismatched++;
            $display("FAIL rise_overrun: Overrun=%h expected 0000", DataRd);
        end
    endtask

    task automatic test_overrun();
        doReset();
        busWrite(4'd0, 16'h0080, 1);
        busWrite(4'd2, 16'h0008, 1);
        Events = 16'h0008;
        waitCycles(4);
        Events = 16'h0000;
        waitCycles(4);
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0008) begin
            nMismatched++;
            $display("FAIL ovr_set: Overrun=%h expected 0008", DataRd);
        end
        busWrite(4'd4, 16'h0008, 1);
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0000) begin
            nMismatched++;
            $display("FAIL ovr_w1c: Overrun=%h expected 0000", DataRd);
        end
        nCompared++;
        if (IntStatus !== 16'h0008) begin
            nMismatched++;
            $display("FAIL ovr_w1c_pending: IntStatus=%h expected 0008", IntStatus);
        end
        // Clear, re-arm, then let IntReset coincide with the next detect.
        @(negedge Clk) IntReset = 16'h0008;
        @(negedge Clk) IntReset = 16'h0000;
        Events = 16'h0008;
        waitCycles(4);
        Events = 16'h0000;
        waitCycles(2);
        IntReset = 16'h0008;
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h0008) begin
            nMismatched++;
            $display("FAIL ovr_coincident_pending: IntStatus=%h expected 0008", IntStatus);
        end
        @(negedge Clk) IntReset = 16'h0000;
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0000) begin
            nMismatched++;
            $display("FAIL ovr_coincident_overrun: Overrun=%h expected 0000", DataRd);
        end
        // W1C commit on the same edge as a new overrun: overrun must survive.
        @(negedge Clk) Events = 16'h0008;
        @(negedge Clk);
        Addr = 4'd4; DataWr = 16'h0008; En = 1'b1; Wr = 1'b1;
        @(negedge Clk) Wr = 1'b0;
        @(negedge Clk) En = 1'b0;
        waitCycles(2);
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0008 || DataRd !== mOverrun) begin
            nMismatched++;
            $display("FAIL ovr_w1c_vs_set: Overrun=%h expected 0008", DataRd);
        end
        busWrite(4'd4, 16'h0008, 1);
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0000) begin
            nMismatched++;
            $display("FAIL ovr_final_clear: Overrun=%h expected 0000", DataRd);
        end
    endtask

    task automatic test_level();
        doReset();
        busWrite(4'd1, 16'h0300, 1);
        busWrite(4'd2, 16'h1000, 1);
        Events = 16'h1000;
        waitCycles(4);
        nCompared++;
        if (IntStatus !== 16'h1000) begin
            nMismatched++;
            $display("FAIL level_set: IntStatus=%h expected 1000", IntStatus);
        end
        IntReset = 16'h1000;
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h1000) begin
            nMismatched++;
            $display("FAIL level_held: IntStatus=%h expected 1000", IntStatus);
        end
        @(negedge Clk) IntReset = 16'h0000;
        waitCycles(3);
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0000) begin
            nMismatched++;
            $display("FAIL level_no_overrun: Overrun=%h expected 0000", DataRd);
        end
        Events = 16'h0000;
        waitCycles(4);
        nCompared++;
        if (IntStatus !== 16'h1000) begin
            nMismatched++;
            $display("FAIL level_after_drop: IntStatus=%h expected 1000", IntStatus);
        end
        IntReset = 16'h1000;
        @(posedge Clk);
        #1;
        nCompared++;
        if (IntStatus !== 16'h0000) begin
            nMismatched++;
            $display("FAIL level_clear: IntStatus=%h expected 0000", IntStatus);
        end
        @(negedge Clk) IntReset = 16'h0000;
    endtask

    task automatic test_enable_bus();
        doReset();
        busWrite(4'd0, 16'hAAAA, 1);
        busWrite(4'd1, 16'hAAAA, 1);
        for (int t = 0; t < 8; t++) begin
            Events = ~Events;
            for (int c = 0; c < 3; c++) begin
                @(negedge Clk);
                nCompared++;
                if (IntStatus !== 16'h0000) begin
                    nMismatched++;
                    $display("FAIL disabled_toggle[%0d]: IntStatus=%h expected 0000", t, IntStatus);
                end
            end
        end
        Events = 16'h0000;
        waitCycles(3);
        busWrite(4'd2, 16'hA5A5, 10);
        Addr = 4'd2;
        #1;
        nCompared++;
        if (DataRd !== 16'hA5A5) begin
            nMismatched++;
            $display("FAIL long_wr_enable: Enable=%h expected a5a5", DataRd);
        end
        // Build an overrun on ch0, then hold a W1C write long enough to span a fresh overrun.
        Events = 16'h0001;
        waitCycles(4);
        Events = 16'h0000;
        waitCycles(4);
        Addr = 4'd4; DataWr = 16'h0001; En = 1'b1; Wr = 1'b1;
        waitCycles(4);
        Events = 16'h0001;
        waitCycles(6);
        Wr = 1'b0;
        @(negedge Clk) En = 1'b0;
        waitCycles(2);
        Addr = 4'd4;
        #1;
        nCompared++;
        if (DataRd !== 16'h0001 || DataRd !== mOverrun) begin
            nMismatched++;
            $display("FAIL single_commit: Overrun=%h expected 0001", DataRd);
        end
        busWrite(4'd3, 16'hFFFF, 1);
        Addr = 4'd3;
        #1;
        nCompared++;
        if (DataRd !== 16'h0001) begin
            nMismatched++;
            $display("FAIL pending_readonly: Pending=%h expected 0001", DataRd);
        end
        busWrite(4'd9, 16'h1234, 1);
        Addr = 4'd9;
        #1;
        nCompared++;
        if (DataRd !== 16'h0000) begin
            nMismatched++;
            $display("FAIL unmapped_read: DataRd=%h expected 0000", DataRd);
        end
        Addr = 4'd2;
        #1;
        nCompared++;
        if (DataRd !== 16'hA5A5) begin
            nMismatched++;
            $display("FAIL unmapped_write_side: Enable=%h expected a5a5", DataRd);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        doReset();
        for (int i = 0; i < 800; i++) begin
            @(negedge Clk);
            nCompared++;
            if (IntStatus !== mPending) begin
                nMismatched++;
                $display("FAIL rand_status[%0d]: IntStatus=%h expected %h", i, IntStatus, mPending);
            end
            a = 4'($urandom_range(0, 15));
            Addr = a;
            #1;
            nCompared++;
            if (DataRd !== expRead(a)) begin
                nMismatched++;
                $display("FAIL rand_read[%0d] addr %0d: DataRd=%h expected %h",
                         i, a, DataRd, expRead(a));
            end
            IntReset = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            if ($urandom_range(0, 2) == 0) Events = Events ^ 16'($urandom);
            if ($urandom_range(0, 30) == 0) begin
                IntReset = 16'h0000;
                busWrite(4'($urandom_range(0, 5)), 16'($urandom), $urandom_range(1, 4));
            end
        end
        IntReset = 16'h0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rising();
        test_overrun();
        test_level();
        test_enable_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/int_event_latch.md
# int_event_latch

Peripheral-side interrupt event latch: the producer end of the interrupt controller's IntStatus/IntReset interface. It synchronizes 16 raw event lines, detects programmable edges or levels, holds each detected event as a pending bit on IntStatus until the controller pulses the matching IntReset bit, and flags events lost while a bit was already pending. CPU register access uses the Xport bus handshake (Addr/En/Rd/Wr).

## Interface
- No parameters; 16 channels fixed.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Addr  in  4  register address.
- DataRd  out  16  read data, combinational from Addr.
- DataWr  in  16  write data; stable while Wr high.
- En  in  1  block select.
- Rd  in  1  read strobe (unused by logic, no side effects on read).
- Wr  in  1  write strobe, asynchronous to Clk, active-high.
- Events  in  16  raw event inputs, asynchronous.
- IntReset  in  16  clear pulses from interrupt controller, one Clk wide per bit.
- IntStatus  out  16  pending bits to interrupt controller.

## Operation
- Registers (Addr): 0 ModeLo (channels 7..0, 2 bits each, ch n at bits 2n+1:2n); 1 ModeHi (channels 15..8); 2 Enable; 3 Pending (read-only, writes ignored); 4 Overrun (read; write-1-to-clear); 5..15 read 0, writes ignored.
- Mode codes: 00 rising edge, 01 falling edge, 10 both edges, 11 high level.
- Event path per channel: Sync1 <= Events; Sync2 <= Sync1; Prev <= Sync2. Detect = mode-selected function of Sync2/Prev (level: Sync2). Detect is gated by Enable bit.
- Pending next = Detect | (Pending & ~IntReset). Event and IntReset on same channel same cycle: Pending stays 1.
- Overrun set when Detect & Pending & ~IntReset (edge modes only; never set in level mode). Cleared only by CPU W1C or Reset. CPU W1C and new overrun same cycle: overrun stays 1.
- Disabling a channel does not clear its Pending or Overrun; it only blocks new detects. Changing mode never creates a detect by itself.
- IntStatus = Pending (direct register output).
- Bus write: AddrSync <= Addr, EnSync <= En, WrSync <= Wr, WrSyncPrev <= WrSync every edge; write commits on the edge where WrSync & ~WrSyncPrev & EnSync, using AddrSync and DataWr. Exactly one commit per Wr pulse regardless of pulse length.
- Reset values: ModeLo 0, ModeHi 0, Enable 0, Pending 0, Overrun 0, all sync/prev flops 0, write-sync flops 0; hence IntStatus 0 and DataRd 0 for Addr 0..15 during/after Reset. Reset asserted mid-write aborts the write; deassertion never produces a spurious commit or detect (Prev and Sync2 both 0).

## Timing
- Event to IntStatus: Events change sampled at edge k -> Sync2 at k+1 -> Pending set at edge k+2 (Detect from Sync2 vs Prev combinational); IntStatus high after edge k+2.
- IntReset bit high at edge j -> IntStatus bit low after edge j (unless concurrent detect).
- Level mode: IntReset clears for one cycle only if Sync2 is low; while level stays high Pending re-asserts each cycle.
- Write: Wr rising sampled at edge m -> register updated at edge m+1; DataWr must be stable through edge m+1.
- Minimum event pulse width for guaranteed detection: 2 Clk periods; minimum separation between counted edges: 2 Clk periods.
- DataRd: zero-latency combinational from Addr and register contents.

## Test plan
- Reset: assert Reset asynchronously mid-cycle with Pending=16'hFFFF -> IntStatus 0 immediately; all reads 0.
- Rising mode: Enable=16'h0001, ModeLo=0, pulse Events[0] 3 cycles -> IntStatus=16'h0001 two edges after first sample; IntReset=16'h0001 one cycle -> IntStatus=0, Overrun=0.
- Overrun and simultaneity: ch3 both-edges, toggle Events[3] twice without clearing -> Overrun=16'h0008; repeat with IntReset[3] coincident with second detect -> Pending=16'h0008, Overrun unchanged; write 16'h0008 to Addr 4 -> Overrun 0.
- Level mode: ch12 mode 11, hold Events[12] high, pulse IntReset[12] -> IntStatus[12] remains 1; drop Events[12] then IntReset -> 0.
- Enable/bus: Enable=0, toggle all Events -> IntStatus 0; hold Wr high 10 cycles writing Enable=16'hA5A5 -> exactly one commit, readback 16'hA5A5; write to Addr 3 -> Pending unchanged.
